seq11_detect_scheduler: RTL and testbench
=========================================

# seq11_detect_scheduler

Round-robin scheduler that time-shares a single Moore "11" sequence-detection engine among N_CH serial bit channels. Each channel's detector state is saved in a small state file and restored whenever that channel is granted. This lets one detect engine serve several serial inputs. The block sits between the serial-bit requesters and the downstream detection consumers. It provides per-channel Moore outputs, a detection strobe, and a saturating hit counter.

## Interface
- N_CH, 4: number of requesting channels (2..16)
- CNT_W, 8: width of the global detection counter
- clk  in  1  rising-edge clock, sole clock
- rst_b  in  1  synchronous, active-high reset; the name is kept per the codebase, the polarity is high
- req  in  N_CH  per-channel request; channel i has a bit to present
- x  in  N_CH  per-channel serial bit; x[i] is meaningful only while req[i]=1
- clr  in  N_CH  per-channel synchronous state clear to S0
- cnt_clr  in  1  synchronous clear of cnt
- gnt  out  N_CH  one-hot grant, combinational, all-zero when nothing is granted
- y  out  N_CH  registered Moore output per channel; 1 iff that channel's state is S2
- det_pulse  out  1  registered one-cycle strobe: the granted channel's next state was S2
- det_ch  out  $clog2(N_CH)  channel index associated with det_pulse
- cnt  out  CNT_W  saturating count of det_pulse events

## Operation
- The per-channel state file holds 2 bits per channel, encoded S0=00, S1=01, S2=10. The value 11 is illegal and is decoded as S0.
- Moore transitions, applied only to the granted channel:
  - x=0: any state -> S0.
  - x=1: S0 -> S1, S1 -> S2, S2 -> S2. Detection is overlapping.
- Non-granted channels hold their state.
- Arbitration:
  - A rotating pointer `ptr` is 0 after reset.
  - `gnt` selects the first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo N_CH.
  - After a grant to channel g, ptr <= (g+1) mod N_CH. With no request, ptr holds.
- Handshake: a requester holds req[i] and x[i] stable until it sees gnt[i]=1. The bit is consumed on the rising edge that ends the grant cycle. The requester may drop or change req and x in the next cycle.
- clr[i]: channel i's state goes to S0 on the next edge.
  - If clr[i] and gnt[i] occur in the same cycle, clr wins: the bit is discarded, state becomes S0, and det_pulse=0.
  - In that case the grant still counts, and ptr advances.
  - clr does not mask gnt.
- det_pulse: asserted for one cycle after a grant cycle whose computed next state is S2 and whose clr is 0. det_ch = the granted index. det_ch holds its last value when det_pulse=0.
- cnt:
  - Increments by 1 in the cycle det_pulse is set.
  - Saturates at 2^CNT_W-1.
  - cnt_clr forces 0 and wins over a same-cycle increment.

## Timing
- Reset (rst_b=1 at an edge): ptr=0, all states S0, y=0, det_pulse=0, det_ch=0, cnt=0. gnt is forced to 0 combinationally while rst_b=1, including mid-operation; a bit presented during reset is discarded.
- Grant latency: 0 cycles. gnt is valid in the same cycle as req.
- State and y latency: y[g] reflects the new state 1 cycle after the grant cycle.
- det_pulse and cnt: 1 cycle after the grant cycle, aligned with y.
- Throughput: one bit per cycle in aggregate. Under full load each channel is served once every N_CH cycles.
- Fairness: a continuously requesting channel waits at most N_CH-1 cycles for a grant.
- Simultaneous events:
  - rst_b overrides clr, cnt_clr, and all grants.
  - clr[i] on a non-granted channel and a grant on another channel are independent.

## Test plan
- Reset: rst_b=1 for 2 cycles with req=4'b1111, x=4'b1111 -> gnt=0000 throughout; after release y=0000, cnt=0, det_pulse=0, and the first grant is 0001.
- Single channel: req=4'b0001 continuously, x[0]=0,1,0,1,1,1 -> y[0] after each edge = 0,0,0,0,1,1; det_pulse high twice with det_ch=0; cnt=2.
- Round-robin:
  - req=4'b1111 for 6 cycles -> gnt 0001,0010,0100,1000,0001,0010.
  - From reset, req=4'b1010 -> gnt 0010,1000,0010,1000.
- State isolation: req=4'b0110, x[1]=1 constant, x[2] alternating 1,0 -> y[1]=1 after channel 1's second grant; y[2] never 1; det_ch is always 1.
- clr collision: channel 0 in S1, req[0]=1, x[0]=1, clr[0]=1 in the same cycle -> gnt[0]=1, next y[0]=0, state S0, no det_pulse, ptr=1.
- Saturation (CNT_W=2): 5 detections -> cnt 1,2,3,3,3. Then cnt_clr=1 in the same cycle as a detection -> cnt=0.

Source files
------------

// File: rtl/seq11_detect_scheduler_if.sv
// Bundle of request, serial-bit and detection-result signals shared between
// the serial-bit requesters/consumers (master) and the scheduler (slave).
interface seq11_detect_scheduler_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) ();
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  x;
  logic [N_CH-1:0]  clr;
  logic             cnt_clr;
  logic [N_CH-1:0]  gnt;
  logic [N_CH-1:0]  y;
  logic             det_pulse;
  logic [CH_W-1:0]  det_ch;
  logic [CNT_W-1:0] cnt;

  // Requester / consumer side.
  modport master (
    output req, x, clr, cnt_clr,
    input  gnt, y, det_pulse, det_ch, cnt
  );

  // Scheduler side.
  modport slave (
    input  req, x, clr, cnt_clr,
    output gnt, y, det_pulse, det_ch, cnt
  );
endinterface

// File: rtl/seq11_detect_scheduler.sv
// Round-robin scheduler sharing one Moore "11" detector among N_CH serial
// channels. Each channel's detector state lives in a small state file and is
// advanced only when that channel holds the grant.
module seq11_detect_scheduler #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_b,   // active-high synchronous reset
  seq11_detect_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } state_t;

  // The unused code 11 is treated as S0 so a corrupted entry self-heals.
  function automatic state_t decode_state(input logic [1:0] s);
    return (s == 2'b11) ? S0 : state_t'(s);
  endfunction

  logic [1:0]       state_reg [N_CH];
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [N_CH-1:0]  gnt;
  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;
  state_t           cur_state;
  state_t           next_state;
  logic             det_next;
  logic             det_pulse_reg;
  logic [PTR_W-1:0] det_ch_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Rotating-priority search starting at ptr; reset suppresses every grant.
  always_comb begin
    logic [PTR_W:0] idx;
    gnt         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N_CH)) begin
        idx = idx - (PTR_W+1)'(N_CH);
      end
      if (!rst_b && !grant_valid && bus.req[idx[PTR_W-1:0]]) begin
        grant_valid             = 1'b1;
        grant_idx               = idx[PTR_W-1:0];
        gnt[idx[PTR_W-1:0]]     = 1'b1;
      end
    end
  end

  // Shared detect engine: next state of the granted channel and its strobe.
  always_comb begin
    cur_state  = decode_state(state_reg[grant_idx]);
    next_state = S0;
    if (bus.x[grant_idx]) begin
      next_state = (cur_state == S0) ? S1 : S2;
    end
    // A same-cycle clear discards the bit, so it can never raise a detection.
    det_next = grant_valid && !bus.clr[grant_idx] && (next_state == S2);
  end

  // Pointer moves just past the winner; it holds when nobody is granted.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_valid) begin
      ptr_next = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Per-channel state file entries; clear beats the grant update.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    always_ff @(posedge clk) begin
      if (rst_b) begin
        state_reg[gi] <= S0;
      end else if (bus.clr[gi]) begin
        state_reg[gi] <= S0;
      end else if (gnt[gi]) begin
        state_reg[gi] <= next_state;
      end
    end

    assign bus.y[gi] = (state_reg[gi] == S2);
  end

  // Detection strobe and the channel it belongs to; det_ch is sticky.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      det_pulse_reg <= 1'b0;
      det_ch_reg    <= '0;
    end else begin
      det_pulse_reg <= det_next;
      if (det_next) begin
        det_ch_reg <= grant_idx;
      end
    end
  end

  // Saturating detection counter, updated on the same edge as det_pulse.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      cnt_reg <= '0;
    end else if (bus.cnt_clr) begin
      cnt_reg <= '0;
    end else if (det_next && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign bus.gnt       = gnt;
  assign bus.det_pulse = det_pulse_reg;
  assign bus.det_ch    = det_ch_reg;
  assign bus.cnt       = cnt_reg;
endmodule

// File: tb/tb_seq11_detect_scheduler.sv
// Directed bench for seq11_detect_scheduler: a default-width instance and a
// 2-bit-counter instance share the same stimulus.
`timescale 1ns/1ps
module tb_seq11_detect_scheduler;
  logic       clk = 1'b0;
  logic       rst_b;
  logic [3:0] req;
  logic [3:0] x;
  logic [3:0] clr;
  logic       cnt_clr;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  seq11_detect_scheduler_if #(.N_CH(4), .CNT_W(8)) bus_a ();
  seq11_detect_scheduler_if #(.N_CH(4), .CNT_W(2)) bus_s ();

  assign bus_a.req     = req;
  assign bus_a.x       = x;
  assign bus_a.clr     = clr;
  assign bus_a.cnt_clr = cnt_clr;
  assign bus_s.req     = req;
  assign bus_s.x       = x;
  assign bus_s.clr     = clr;
  assign bus_s.cnt_clr = cnt_clr;

  seq11_detect_scheduler #(.N_CH(4), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_a)
  );

  seq11_detect_scheduler #(.N_CH(4), .CNT_W(2)) dut_s (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_b = 1'b1; req = '0; x = '0; clr = '0; cnt_clr = 1'b0;
    tick();
    tick();
    rst_b = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b1; req = 4'b1111; x = 4'b1111; clr = '0; cnt_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (bus_a.gnt !== 4'b0000) begin
        bad++; $display("FAIL reset_gnt c=%0d got=%b exp=0000", c, bus_a.gnt);
      end
      $display("reset c=%0d gnt=%b", c, bus_a.gnt);
      @(posedge clk);
      #1;
    end
    rst_b = 1'b0;
    #1;
    total++;
    if (bus_a.y !== 4'b0000) begin bad++; $display("FAIL reset_y got=%b exp=0000", bus_a.y); end
    total++;
    if (bus_a.cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus_a.cnt); end
    total++;
    if (bus_s.cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt_s got=%0d exp=0", bus_s.cnt); end
    total++;
    if (bus_a.det_pulse !== 1'b0) begin bad++; $display("FAIL reset_det got=%b exp=0", bus_a.det_pulse); end
    total++;
    if (bus_a.det_ch !== 2'd0) begin bad++; $display("FAIL reset_det_ch got=%0d exp=0", bus_a.det_ch); end
    total++;
    if (bus_a.gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=0001", bus_a.gnt); end
    $display("reset released gnt=%b y=%b cnt=%0d", bus_a.gnt, bus_a.y, bus_a.cnt);
    // Two grants move ptr to 2; a mid-run reset must kill gnt and rewind ptr.
    tick();
    total++;
    if (bus_a.gnt !== 4'b0010) begin bad++; $display("FAIL reset_second_gnt got=%b exp=0010", bus_a.gnt); end
    tick();
    rst_b = 1'b1;
    #1;
    total++;
    if (bus_a.gnt !== 4'b0000) begin bad++; $display("FAIL reset_mid_gnt got=%b exp=0000", bus_a.gnt); end
    tick();
    rst_b = 1'b0;
    #1;
    total++;
    if (bus_a.gnt !== 4'b0001) begin bad++; $display("FAIL reset_ptr_rewind got=%b exp=0001", bus_a.gnt); end
    $display("reset mid-run rewind gnt=%b", bus_a.gnt);
  endtask

  task automatic test_single();
    logic bits  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_y [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   exp_c [6] = '{0, 0, 0, 0, 1, 2};
    apply_reset();
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      x[0] = bits[i];
      #1;
      total++;
      if (bus_a.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt i=%0d got=%b exp=0001", i, bus_a.gnt); end
      tick();
      total++;
      if (bus_a.y !== {3'b000, exp_y[i]}) begin
        bad++; $display("FAIL single_y i=%0d got=%b exp=%b", i, bus_a.y, {3'b000, exp_y[i]});
      end
      total++;
      if (bus_a.det_pulse !== exp_y[i]) begin
        bad++; $display("FAIL single_det i=%0d got=%b exp=%b", i, bus_a.det_pulse, exp_y[i]);
      end
      total++;
      if (bus_a.det_ch !== 2'd0) begin bad++; $display("FAIL single_det_ch i=%0d got=%0d exp=0", i, bus_a.det_ch); end
      total++;
      if (bus_a.cnt !== 8'(exp_c[i])) begin
        bad++; $display("FAIL single_cnt i=%0d got=%0d exp=%0d", i, bus_a.cnt, exp_c[i]);
      end
      $display("single i=%0d x=%b y=%b det=%b cnt=%0d", i, bits[i], bus_a.y, bus_a.det_pulse, bus_a.cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_full [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] exp_odd  [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (bus_a.gnt !== exp_full[i]) begin
        bad++; $display("FAIL rr_full i=%0d got=%b exp=%b", i, bus_a.gnt, exp_full[i]);
      end
      $display("rr_full i=%0d gnt=%b", i, bus_a.gnt);
      tick();
    end
    apply_reset();
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus_a.gnt !== exp_odd[i]) begin
        bad++; $display("FAIL rr_1010 i=%0d got=%b exp=%b", i, bus_a.gnt, exp_odd[i]);
      end
      $display("rr_1010 i=%0d gnt=%b", i, bus_a.gnt);
      tick();
    end
  endtask

  task automatic test_isolation();
    logic [3:0] exp_g  [8] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100,
                               4'b0010, 4'b0100, 4'b0010, 4'b0100};
    logic       x2     [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_y1 [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_d  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    req = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      x = {1'b0, x2[i], 1'b1, 1'b0};
      #1;
      total++;
      if (bus_a.gnt !== exp_g[i]) begin
        bad++; $display("FAIL iso_gnt i=%0d got=%b exp=%b", i, bus_a.gnt, exp_g[i]);
      end
      tick();
      total++;
      if (bus_a.y !== {2'b00, exp_y1[i], 1'b0}) begin
        bad++; $display("FAIL iso_y i=%0d got=%b exp=%b", i, bus_a.y, {2'b00, exp_y1[i], 1'b0});
      end
      total++;
      if (bus_a.det_pulse !== exp_d[i]) begin
        bad++; $display("FAIL iso_det i=%0d got=%b exp=%b", i, bus_a.det_pulse, exp_d[i]);
      end
      if (exp_d[i]) begin
        total++;
        if (bus_a.det_ch !== 2'd1) begin
          bad++; $display("FAIL iso_det_ch i=%0d got=%0d exp=1", i, bus_a.det_ch);
        end
      end
      $display("iso i=%0d gnt=%b y=%b det=%b ch=%0d", i, exp_g[i], bus_a.y, bus_a.det_pulse, bus_a.det_ch);
    end
  endtask

  task automatic test_clr_collision();
    apply_reset();
    // Channel 0 to S1, then serve channel 1 so ptr sits at 2.
    req = 4'b0001; x = 4'b0001;
    tick();
    req = 4'b0010; x = 4'b0000;
    tick();
    // Collision: grant and clear on channel 0 together.
    req = 4'b0001; x = 4'b0001; clr = 4'b0001;
    #1;
    total++;
    if (bus_a.gnt !== 4'b0001) begin bad++; $display("FAIL clr_gnt got=%b exp=0001", bus_a.gnt); end
    tick();
    clr = 4'b0000;
    total++;
    if (bus_a.y[0] !== 1'b0) begin bad++; $display("FAIL clr_y0 got=%b exp=0", bus_a.y[0]); end
    total++;
    if (bus_a.det_pulse !== 1'b0) begin bad++; $display("FAIL clr_det got=%b exp=0", bus_a.det_pulse); end
    total++;
    if (bus_a.cnt !== 8'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", bus_a.cnt); end
    $display("clr collision y=%b det=%b cnt=%0d", bus_a.y, bus_a.det_pulse, bus_a.cnt);
    // ptr must have advanced to 1.
    req = 4'b1111; x = 4'b0000;
    #1;
    total++;
    if (bus_a.gnt !== 4'b0010) begin bad++; $display("FAIL clr_ptr got=%b exp=0010", bus_a.gnt); end
    tick();
    // Channel 0 must restart from S0: a single 1 only reaches S1.
    req = 4'b0001; x = 4'b0001;
    #1;
    total++;
    if (bus_a.gnt !== 4'b0001) begin bad++; $display("FAIL clr_regrant got=%b exp=0001", bus_a.gnt); end
    tick();
    total++;
    if (bus_a.y[0] !== 1'b0 || bus_a.det_pulse !== 1'b0) begin
      bad++; $display("FAIL clr_restart got=y%b/d%b exp=y0/d0", bus_a.y[0], bus_a.det_pulse);
    end
    $display("clr restart y=%b det=%b", bus_a.y, bus_a.det_pulse);
  endtask

  task automatic test_saturation();
    int exp_cs [6] = '{0, 1, 2, 3, 3, 3};
    apply_reset();
    req = 4'b0001; x = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (bus_s.cnt !== 2'(exp_cs[i])) begin
        bad++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, bus_s.cnt, exp_cs[i]);
      end
      $display("sat i=%0d det=%b cnt_s=%0d cnt_a=%0d", i, bus_s.det_pulse, bus_s.cnt, bus_a.cnt);
    end
    total++;
    if (bus_a.cnt !== 8'd5) begin bad++; $display("FAIL sat_wide_cnt got=%0d exp=5", bus_a.cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++;
    if (bus_s.cnt !== 2'd0) begin bad++; $display("FAIL sat_clr_cnt got=%0d exp=0", bus_s.cnt); end
    total++;
    if (bus_s.det_pulse !== 1'b1) begin bad++; $display("FAIL sat_clr_det got=%b exp=1", bus_s.det_pulse); end
    total++;
    if (bus_a.cnt !== 8'd0) begin bad++; $display("FAIL sat_clr_wide got=%0d exp=0", bus_a.cnt); end
    $display("sat cnt_clr cnt_s=%0d det=%b", bus_s.cnt, bus_s.det_pulse);
    tick();
    total++;
    if (bus_s.cnt !== 2'd1) begin bad++; $display("FAIL sat_after_clr got=%0d exp=1", bus_s.cnt); end
    $display("sat after clr cnt_s=%0d", bus_s.cnt);
  endtask

  initial begin
    rst_b = 1'b1; req = '0; x = '0; clr = '0; cnt_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_isolation();
    test_clr_collision();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
